// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-requester arbiter in front of one SDRAM controller port,
// with bounded hold per grant and an in-order tag FIFO that routes read data back.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int HOLD    = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                arb_error
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    localparam int CW = $clog2(HOLD + 1);
    localparam int PW = $clog2(MAX_OUT);
    localparam int FW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] HOLD_V = CW'(HOLD);
    localparam logic [FW-1:0] FULL_V = FW'(MAX_OUT);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               arb_error_q, arb_error_d;
    logic [PW-1:0]      wp_q, wp_d, rp_q, rp_d;
    logic [FW-1:0]      fcnt_q, fcnt_d;
    logic [MAX_OUT-1:0] tag_q, tag_d;

    logic req0, req1, owned, sel, req_own, req_oth, rel, act;
    logic full, empty, accept, push, pop, tag, own_read, own_write;

    always_comb begin
        req0      = m0_read | m0_write;
        req1      = m1_read | m1_write;
        owned     = state_q != IDLE;
        sel       = state_q == OWN1;
        req_own   = sel ? req1 : req0;
        req_oth   = sel ? req0 : req1;
        // The release cycle carries no command so the handover never splits a transfer.
        rel       = owned & (~req_own | ((cnt_q == HOLD_V) & req_oth));
        act       = owned & ~rel;
        full      = fcnt_q == FULL_V;
        empty     = fcnt_q == '0;
        own_read  = sel ? m1_read : m0_read;
        own_write = sel ? m1_write : m0_write;
        s_write   = act & own_write;
        s_read    = act & own_read & ~full;
        s_address    = owned ? (sel ? m1_address : m0_address) : '0;
        s_writedata  = owned ? (sel ? m1_writedata : m0_writedata) : '0;
        s_byteenable = owned ? (sel ? m1_byteenable : m0_byteenable) : '0;
        m0_waitrequest = (act & ~sel) ? (s_waitrequest | (m0_read & full)) : 1'b1;
        m1_waitrequest = (act & sel) ? (s_waitrequest | (m1_read & full)) : 1'b1;
        accept = (s_read | s_write) & ~s_waitrequest;
        push   = accept & s_read;
        pop    = s_readdatavalid & ~empty;
        tag    = tag_q[rp_q];
        m0_readdatavalid = pop & ~tag;
        m1_readdatavalid = pop & tag;
        m0_readdata = s_readdata;
        m1_readdata = s_readdata;
        arb_error   = arb_error_q;
        state_d = state_q;
        if (!owned)
            state_d = (req0 & (~req1 | last_q)) ? OWN0 : (req1 ? OWN1 : IDLE);
        else if (rel)
            state_d = req_oth ? (sel ? OWN0 : OWN1) : IDLE;
        last_d = (state_d == OWN0) ? 1'b0 : (state_d == OWN1) ? 1'b1 : last_q;
        cnt_d  = (state_d != state_q) ? '0 : (accept & (cnt_q != HOLD_V)) ? cnt_q + CW'(1) : cnt_q;
        tag_d = tag_q;
        if (push)
            tag_d[wp_q] = sel;
        wp_d   = push ? wp_q + PW'(1) : wp_q;
        rp_d   = pop ? rp_q + PW'(1) : rp_q;
        fcnt_d = fcnt_q + FW'(push) - FW'(pop);
        arb_error_d = arb_error_q | (s_readdatavalid & empty);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            arb_error_q <= 1'b0;
            wp_q        <= '0;
            rp_q        <= '0;
            fcnt_q      <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            arb_error_q <= arb_error_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            fcnt_q      <= fcnt_d;
            tag_q       <= tag_d;
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed stimulus with a queue-based reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_sdram_port_arbiter;
    localparam int HOLD    = 4;
    localparam int MAX_OUT = 8;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [24:0] ma [2];
    logic        mr [2];
    logic        mw [2];
    logic [15:0] mwd [2];
    logic [1:0]  mbe [2];
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [15:0] m0_readdata, m1_readdata;
    logic [24:0] s_address;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid, arb_error;
    logic [15:0] s_writedata, s_readdata;
    logic [1:0]  s_byteenable;

    int vectors = 0;
    int miscompares = 0;

    sdram_port_arbiter #(.ADDR_W(25), .DATA_W(16), .HOLD(HOLD), .MAX_OUT(MAX_OUT)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .m0_address(ma[0]), .m0_read(mr[0]), .m0_write(mw[0]), .m0_writedata(mwd[0]),
        .m0_byteenable(mbe[0]), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(ma[1]), .m1_read(mr[1]), .m1_write(mw[1]), .m1_writedata(mwd[1]),
        .m1_byteenable(mbe[1]), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .arb_error(arb_error)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = none), transfers in this grant, last served, tag queue.
    int   own = -1, cnt = 0, last = 1;
    logic err = 1'b0;
    int   q[$];
    logic [1:0]  rq, e_wait, e_rdv;
    logic        rel, act, full, e_sr, e_sw, acc;
    logic [24:0] e_addr;
    logic [15:0] e_wd;
    logic [1:0]  e_be;

    always @(negedge clk_clk) begin
        if (reset_reset) begin
            chk("rst_s_rw", {30'd0, s_read, s_write}, 0);
            chk("rst_s_addr", {7'd0, s_address}, 0);
            chk("rst_s_wd_be", {14'd0, s_writedata, s_byteenable}, 0);
            chk("rst_wait", {30'd0, m1_waitrequest, m0_waitrequest}, 3);
            chk("rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 0);
            chk("rst_err", {31'd0, arb_error}, 0);
            own = -1; cnt = 0; last = 1; err = 1'b0; q.delete();
        end else begin
            rq[0] = mr[0] | mw[0];
            rq[1] = mr[1] | mw[1];
            full = q.size() == MAX_OUT;
            rel = 0; act = 0; e_sr = 0; e_sw = 0; e_addr = '0; e_wd = '0; e_be = '0;
            if (own >= 0) begin
                rel = !rq[own] || (cnt >= HOLD && rq[1-own]);
                act = !rel;
                e_addr = ma[own]; e_wd = mwd[own]; e_be = mbe[own];
                e_sw = act && mw[own];
                e_sr = act && mr[own] && !full;
            end
            for (int i = 0; i < 2; i++)
                e_wait[i] = (act && own == i) ? (s_waitrequest || (mr[i] && full)) : 1'b1;
            e_rdv = '0;
            if (s_readdatavalid && q.size() > 0) e_rdv[q[0]] = 1'b1;
            chk("m_s_read", {31'd0, s_read}, {31'd0, e_sr});
            chk("m_s_write", {31'd0, s_write}, {31'd0, e_sw});
            chk("m_s_addr", {7'd0, s_address}, {7'd0, e_addr});
            chk("m_s_wd_be", {14'd0, s_writedata, s_byteenable}, {14'd0, e_wd, e_be});
            chk("m_wait", {30'd0, m1_waitrequest, m0_waitrequest}, {30'd0, e_wait});
            chk("m_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, {30'd0, e_rdv});
            chk("m_rdata", {m1_readdata, m0_readdata}, {s_readdata, s_readdata});
            chk("m_err", {31'd0, arb_error}, {31'd0, err});
            if (s_readdatavalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else err = 1'b1;
            end
            acc = (e_sr || e_sw) && !s_waitrequest;
            if (acc && e_sr) q.push_back(own);
            if (own < 0) begin
                own = (rq[0] && rq[1]) ? 1 - last : rq[0] ? 0 : rq[1] ? 1 : -1;
                cnt = 0;
                if (own >= 0) last = own;
            end else if (rel) begin
                own = rq[1-own] ? 1 - own : -1;
                cnt = 0;
                if (own >= 0) last = own;
            end else if (acc) cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk_clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk_clk); #1;
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        cyc(); cyc();
        reset_reset = 1'b0;
    endtask

    task automatic do_read(input int p, input logic [24:0] a);
        logic got = 1'b0;
        mr[p] = 1'b1; ma[p] = a;
        for (int k = 0; k < 8; k++) begin
            at_neg();
            if (!(p == 0 ? m0_waitrequest : m1_waitrequest)) begin
                got = 1'b1; cyc(); break;
            end
            cyc();
        end
        mr[p] = 1'b0;
        chk("d_accept", {31'd0, got}, 1);
    endtask

    int exp_seq [15] = '{2, 0, 0, 0, 0, 2, 1, 1, 1, 1, 2, 0, 0, 0, 0};
    int who;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            ma[i] = '0; mr[i] = 1'b0; mw[i] = 1'b0;
        end
        mwd[0] = 16'h1234; mwd[1] = 16'hABCD; mbe[0] = 2'b01; mbe[1] = 2'b10;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        reset_reset = 1'b0;
        #1 reset_reset = 1'b1;
        repeat (3) cyc();
        reset_reset = 1'b0;
        // single read on m0
        cyc();
        ma[0] = 25'h000123; mr[0] = 1'b1;
        at_neg();
        chk("a_idle_sread", {31'd0, s_read}, 0);
        chk("a_idle_wait", {31'd0, m0_waitrequest}, 1);
        cyc();
        at_neg();
        chk("a_sread", {31'd0, s_read}, 1);
        chk("a_addr", {7'd0, s_address}, 32'h123);
        cyc(); mr[0] = 1'b0;
        cyc(); cyc();
        s_readdatavalid = 1'b1; s_readdata = 16'hBEEF;
        at_neg();
        chk("a_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 1);
        chk("a_data", {16'd0, m0_readdata}, 32'hBEEF);
        cyc(); s_readdatavalid = 1'b0;
        // both ports writing continuously from reset
        ma[0] = 25'hA0; ma[1] = 25'hB0; mw[0] = 1'b1; mw[1] = 1'b1;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            at_neg();
            who = (s_write && !s_waitrequest) ? (s_address == 25'hA0 ? 0 : 1) : 2;
            chk("b_hold_seq", who, exp_seq[k]);
            cyc();
        end
        mw[0] = 1'b0; mw[1] = 1'b0;
        // tag FIFO fills at MAX_OUT reads
        do_reset();
        mr[1] = 1'b1; ma[1] = 25'h200;
        for (int j = 0; j < 10; j++) begin
            at_neg();
            chk("c_sread", {31'd0, s_read}, (j >= 1 && j <= 8) ? 1 : 0);
            if (j == 9) chk("c_wait_full", {31'd0, m1_waitrequest}, 1);
            cyc();
        end
        s_readdatavalid = 1'b1; s_readdata = 16'h5A5A;
        at_neg();
        chk("c_pop_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 2);
        chk("c_pop_sread", {31'd0, s_read}, 0);
        cyc(); s_readdatavalid = 1'b0;
        at_neg();
        chk("c_ninth", {31'd0, s_read & ~s_waitrequest}, 1);
        cyc(); mr[1] = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 16'h6000;
        repeat (8) cyc();
        s_readdatavalid = 1'b0;
        cyc();
        // interleaved reads routed in order
        do_read(0, 25'h10);
        do_read(1, 25'h20);
        do_read(0, 25'h30);
        cyc();
        s_readdatavalid = 1'b1; s_readdata = 16'h1111;
        at_neg();
        chk("d_route0", {30'd0, m1_readdatavalid, m0_readdatavalid}, 1);
        chk("d_data0", {16'd0, m0_readdata}, 32'h1111);
        cyc(); s_readdata = 16'h2222;
        at_neg();
        chk("d_route1", {30'd0, m1_readdatavalid, m0_readdatavalid}, 2);
        chk("d_data1", {16'd0, m1_readdata}, 32'h2222);
        cyc(); s_readdata = 16'h3333;
        at_neg();
        chk("d_route2", {30'd0, m1_readdatavalid, m0_readdatavalid}, 1);
        cyc(); s_readdatavalid = 1'b0;
        // slave stall on a write
        mw[0] = 1'b1; ma[0] = 25'h77; s_waitrequest = 1'b1;
        cyc(); cyc();
        at_neg();
        chk("s_stall_wait", {31'd0, m0_waitrequest}, 1);
        chk("s_stall_write", {31'd0, s_write}, 1);
        cyc(); s_waitrequest = 1'b0;
        at_neg();
        chk("s_go_wait", {31'd0, m0_waitrequest}, 0);
        cyc(); mw[0] = 1'b0;
        cyc();
        // reset with reads outstanding, then a stray response
        mr[0] = 1'b1; ma[0] = 25'h40;
        repeat (4) cyc();
        mr[0] = 1'b0;
        do_reset();
        cyc();
        s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
        at_neg();
        chk("e_no_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 0);
        chk("e_err_pre", {31'd0, arb_error}, 0);
        cyc(); s_readdatavalid = 1'b0;
        at_neg();
        chk("e_err", {31'd0, arb_error}, 1);
        cyc(); cyc();
        at_neg();
        chk("e_err_sticky", {31'd0, arb_error}, 1);
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, SDRAM controller word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter HOLD, default 4, the maximum number of consecutive accepted transfers per grant while the other port is requesting.
REQ-004 SHALL have parameter MAX_OUT, default 8 (power of 2), the depth of the outstanding-read tag FIFO.
REQ-005 clk_clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset_reset  in  1  asynchronous, active-high reset.
REQ-007 m<i>_address (i=0,1)  in  ADDR_W  requester word address.
REQ-008 m<i>_read / m<i>_write  in  1 each  requester command strobes; both high at once is illegal.
REQ-009 m<i>_writedata  in  DATA_W  requester write data.
REQ-010 m<i>_byteenable  in  DATA_W/8  requester byte lanes.
REQ-011 m<i>_waitrequest  out  1  high = command not accepted this cycle.
REQ-012 m<i>_readdata  out  DATA_W  returned read data, broadcast to both requesters.
REQ-013 m<i>_readdatavalid  out  1  m<i>_readdata is valid for this requester.
REQ-014 s_address, s_read, s_write, s_writedata, s_byteenable  out  ADDR_W/1/1/DATA_W/DATA_W/8  command to the SDRAM controller slave.
REQ-015 s_waitrequest, s_readdata, s_readdatavalid  in  1/DATA_W/1  SDRAM controller response.
REQ-016 arb_error  out  1  sticky flag: s_readdatavalid received with the tag FIFO empty.

Function
REQ-017 SHALL use an owner state machine with states IDLE, OWN0 and OWN1.
REQ-018 A port SHALL be requesting when its read or write is high.
REQ-019 From IDLE, when any port is requesting, the FSM SHALL move to OWN<i> on the next edge; if both request, the port not served last wins (port 0 wins after reset).
REQ-020 Arbitration latency SHALL be exactly 1 cycle; in IDLE, s_read and s_write are 0 and both waitrequests are 1.
REQ-021 In OWN<i>, s_address, s_writedata and s_byteenable SHALL combinationally follow m<i>.
REQ-022 In OWN<i>, s_write SHALL equal m<i>_write.
REQ-023 In OWN<i>, s_read SHALL equal m<i>_read AND NOT fifo_full.
REQ-024 m<i>_waitrequest SHALL equal s_waitrequest OR (m<i>_read AND fifo_full); the non-owner's waitrequest SHALL be 1.
REQ-025 A transfer SHALL be accepted when (s_read OR s_write) AND NOT s_waitrequest.
REQ-026 Each accepted transfer SHALL increment a grant counter, which is cleared on every grant change.
REQ-027 The owner SHALL be released when it is not requesting, or when the counter reaches HOLD while the other port is requesting.
REQ-028 On release, the FSM SHALL go directly to OWN<other> if the other port is requesting, else to IDLE; no transfer is accepted in the release cycle.
REQ-029 Each accepted read SHALL push the owner id into the tag FIFO.
REQ-030 Each s_readdatavalid SHALL pop the tag FIFO and assert m<tag>_readdatavalid in the same cycle, with m<tag>_readdata = s_readdata.
REQ-031 A simultaneous push and pop SHALL keep the FIFO count unchanged; a push at full cannot occur (REQ-023).
REQ-032 s_readdatavalid with the FIFO empty SHALL be dropped (no m_readdatavalid asserted) and SHALL set arb_error.
REQ-033 Writes SHALL never be blocked by FIFO state.

Reset
REQ-034 While reset_reset is high: state IDLE, counter 0, tag FIFO empty, last-served = port 1, arb_error 0, s_read/s_write 0, s_address/s_writedata/s_byteenable 0, both waitrequest 1, both readdatavalid 0.
REQ-035 Reset mid-operation SHALL discard outstanding tags; responses arriving after reset are handled per REQ-032.

Verification
REQ-036 Single read on m0 at address 0x000123, s_waitrequest=0, data returned 3 cycles later: s_read high 1 cycle after the request -> m0_readdatavalid=1 with data 0xBEEF; m1_readdatavalid stays 0.
REQ-037 m0 and m1 both write continuously from reset, HOLD=4: accepted sequence is 4 m0 writes, 1 idle cycle, 4 m1 writes, 1 idle cycle, repeating.
REQ-038 m1 issues 9 back-to-back reads with readdatavalid held off: 8 accepted, then m1_waitrequest=1 and s_read=0; one s_readdatavalid -> a ninth read accepted on the following cycle.
REQ-039 Interleaved reads m0,m1,m0 with in-order responses 0x1111, 0x2222, 0x3333 -> routed to m0, m1, m0 respectively.
REQ-040 Assert reset with 3 reads outstanding, release it, then inject one s_readdatavalid -> no m_readdatavalid asserted, arb_error=1.
